// File: rtl/openhw_ebu_pkg.sv
// Shared types and AHB encodings for the external bus unit arbiter.
// burst_beats() returns the index of the last beat of a burst.
package openhw_ebu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LSU_OWN     = 3'd1,
    ST_IFU_OWN     = 3'd2,
    ST_LSU_RESTORE = 3'd3,
    ST_IFU_RESTORE = 3'd4
  } ebu_state_e;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Undefined-length and wrapping encodings are treated as single beats.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] last;
    case (hburst)
      HBURST_SINGLE: last = 4'd0;
      HBURST_INCR4:  last = 4'd3;
      HBURST_INCR8:  last = 4'd7;
      HBURST_INCR16: last = 4'd15;
      default:       last = 4'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/openhw_ebu_arbiter_if.sv
// Request, bus-phase and control signals between the two controller-input
// stages and the arbiter; master = stage/bus side, slave = arbiter side.
interface openhw_ebu_arbiter_if;

  logic       LSUReq;
  logic       IFUReq;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;

  logic       LSUSave;
  logic       IFUSave;
  logic       LSURestore;
  logic       IFURestore;
  logic       LSUDisable;
  logic       IFUDisable;
  logic       LSUSelect;
  logic       IFUSelect;

  modport master (
    output LSUReq, IFUReq, HTRANS, HBURST, HREADY,
    input  LSUSave, IFUSave, LSURestore, IFURestore,
    input  LSUDisable, IFUDisable, LSUSelect, IFUSelect
  );

  modport slave (
    input  LSUReq, IFUReq, HTRANS, HBURST, HREADY,
    output LSUSave, IFUSave, LSURestore, IFURestore,
    output LSUDisable, IFUDisable, LSUSelect, IFUSelect
  );

endinterface

// File: rtl/openhw_ebu_beatcounter.sv
// Counts accepted beats of the current burst and flags the final one.
// The counter saturates at 15 and clears after the final beat.
module openhw_ebu_beatcounter
  import openhw_ebu_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  output logic       BeatAccepted,
  output logic       FinalBeat
);

  logic [3:0] count_q;
  logic [3:0] count_d;
  logic [3:0] lastIdx;

  assign BeatAccepted = HREADY && (HTRANS != HTRANS_IDLE);
  assign lastIdx      = burst_beats(HBURST);
  assign FinalBeat    = BeatAccepted && (count_q == lastIdx);

  always_comb begin
    count_d = count_q;
    if (FinalBeat) begin
      count_d = 4'd0;
    end else if (BeatAccepted && (count_q != 4'hF)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/openhw_ebu_arbiter.sv
// Two-manager AHB arbiter: bursts run to completion, a losing manager's
// first address phase is saved and replayed right after the owner finishes.
module openhw_ebu_arbiter
  import openhw_ebu_pkg::*;
#(
  parameter bit LSU_PRIORITY = 1'b1
) (
  input logic                 HCLK,
  input logic                 HRESET,
  openhw_ebu_arbiter_if.slave bus
);

  ebu_state_e state_q;
  ebu_state_e state_d;
  logic       lsuPending_q;
  logic       lsuPending_d;
  logic       ifuPending_q;
  logic       ifuPending_d;

  logic       beatAccepted;
  logic       finalBeat;
  logic       selLsu;
  logic       restoreSel;
  logic       otherReq;
  logic       otherPending;
  logic       saveOther;

  openhw_ebu_beatcounter u_beatcounter (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HTRANS       (bus.HTRANS),
    .HBURST       (bus.HBURST),
    .HREADY       (bus.HREADY),
    .BeatAccepted (beatAccepted),
    .FinalBeat    (finalBeat)
  );

  // A pending manager seen in IDLE is replayed there, exactly as in RESTORE.
  always_comb begin
    selLsu     = LSU_PRIORITY;
    restoreSel = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (lsuPending_q && (LSU_PRIORITY || !ifuPending_q)) begin
          selLsu     = 1'b1;
          restoreSel = 1'b1;
        end else if (ifuPending_q) begin
          selLsu     = 1'b0;
          restoreSel = 1'b1;
        end else if (bus.LSUReq && bus.IFUReq) begin
          selLsu = LSU_PRIORITY;
        end else if (bus.LSUReq) begin
          selLsu = 1'b1;
        end else if (bus.IFUReq) begin
          selLsu = 1'b0;
        end
      end
      ST_LSU_OWN: begin
        selLsu = 1'b1;
      end
      ST_IFU_OWN: begin
        selLsu = 1'b0;
      end
      ST_LSU_RESTORE: begin
        selLsu     = 1'b1;
        restoreSel = 1'b1;
      end
      ST_IFU_RESTORE: begin
        selLsu     = 1'b0;
        restoreSel = 1'b1;
      end
      default: begin
        selLsu     = LSU_PRIORITY;
        restoreSel = 1'b0;
      end
    endcase
  end

  always_comb begin
    otherReq     = selLsu ? bus.IFUReq : bus.LSUReq;
    otherPending = selLsu ? ifuPending_q : lsuPending_q;
    saveOther    = otherReq && !otherPending;
  end

  // The next RESTORE target uses the updated pending flags, so a request
  // saved in the final-beat cycle is replayed immediately afterwards.
  always_comb begin
    state_d      = state_q;
    lsuPending_d = lsuPending_q;
    ifuPending_d = ifuPending_q;

    if (saveOther) begin
      if (selLsu) begin
        ifuPending_d = 1'b1;
      end else begin
        lsuPending_d = 1'b1;
      end
    end

    if (restoreSel && beatAccepted) begin
      if (selLsu) begin
        lsuPending_d = 1'b0;
      end else begin
        ifuPending_d = 1'b0;
      end
    end

    if (beatAccepted) begin
      if (finalBeat) begin
        if (lsuPending_d && (LSU_PRIORITY || !ifuPending_d)) begin
          state_d = ST_LSU_RESTORE;
        end else if (ifuPending_d) begin
          state_d = ST_IFU_RESTORE;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (selLsu) begin
        state_d = ST_LSU_OWN;
      end else begin
        state_d = ST_IFU_OWN;
      end
    end else if ((state_q == ST_IDLE) && restoreSel) begin
      if (selLsu) begin
        state_d = ST_LSU_RESTORE;
      end else begin
        state_d = ST_IFU_RESTORE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      lsuPending_q <= 1'b0;
      ifuPending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lsuPending_q <= lsuPending_d;
      ifuPending_q <= ifuPending_d;
    end
  end

  assign bus.LSUSelect  = selLsu;
  assign bus.IFUSelect  = !selLsu;
  assign bus.LSUDisable = !selLsu;
  assign bus.IFUDisable = selLsu;
  assign bus.LSUSave    = saveOther && !selLsu;
  assign bus.IFUSave    = saveOther && selLsu;
  assign bus.LSURestore = restoreSel && selLsu;
  assign bus.IFURestore = restoreSel && !selLsu;

endmodule
